// File: rtl/shift_pkg.sv
// Shared constants, encodings and helpers for the shared-shifter sequencer.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int CTRL_W  = SHAMT_W + 2;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    RESP  = 2'b11
  } state_e;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [SHAMT_W-1:0] shamt,
                                                  input logic [1:0]         sh_type);
    return {shamt, sh_type};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the other requester
// whenever a served operation completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid_i,
  input  logic       advance_i,
  input  logic       served_id_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~served_id_i;
    end
  end

  // Pointer only breaks ties; a lone requester is granted regardless.
  always_comb begin
    grant_o = req_valid_i;
    if (&req_valid_i) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Shared-shifter controller: arbitrates two requesters and builds ASR/ROR
// out of up to two LSL/LSR passes through an external barrel shifter.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [1:0]        req0_op,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [1:0]        req1_op,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic [DATA_W-1:0] sh_in,
  output logic [CTRL_W-1:0] sh_ctrl,
  input  logic [DATA_W-1:0] sh_out
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [1:0]          op_q, op_d;
  logic [SHAMT_W-1:0]  shamt_q, shamt_d;
  logic                id_q, id_d;

  logic [1:0]          grant;
  logic                idle;
  logic                accept;
  logic                rsp_hs;
  logic                two_pass;
  logic [SHAMT_W-1:0]  ror_back_amt;

  assign idle       = (state_q == IDLE) && !reset;
  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs     = (state_q == RESP) && rsp_ready;

  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = acc_q;
  assign rsp_id     = id_q;

  // Positive ASR operands are already correct after the logical right pass.
  assign two_pass = (shamt_q != '0) &&
                    ((op_q == OP_ROR) || ((op_q == OP_ASR) && data_q[DATA_W-1]));
  assign ror_back_amt = -shamt_q;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i ({req1_valid, req0_valid}),
    .advance_i   (rsp_hs),
    .served_id_i (id_q),
    .grant_o     (grant)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    id_d    = id_q;
    acc_d   = acc_q;
    sh_in   = '0;
    sh_ctrl = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = req1_ready;
          data_d  = req1_ready ? req1_data  : req0_data;
          op_d    = req1_ready ? req1_op    : req0_op;
          shamt_d = req1_ready ? req1_shamt : req0_shamt;
          state_d = PASS1;
        end
      end
      PASS1: begin
        sh_in   = data_q;
        sh_ctrl = pack_ctrl(shamt_q, (op_q == OP_LSL) ? SH_LSL : SH_LSR);
        acc_d   = sh_out;
        state_d = two_pass ? PASS2 : RESP;
      end
      PASS2: begin
        if (op_q == OP_ROR) begin
          sh_in   = data_q;
          sh_ctrl = pack_ctrl(ror_back_amt, SH_LSL);
          acc_d   = acc_q | sh_out;
        end else begin
          // Inverted right-shift of all-ones yields the sign-fill mask.
          sh_in   = '1;
          sh_ctrl = pack_ctrl(shamt_q, SH_LSR);
          acc_d   = acc_q | ~sh_out;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      shamt_q <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      id_q    <= id_d;
    end
  end

endmodule
